// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader: FSM encoding and word/byte sizing helpers.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package imem_loader_pkg;

    typedef enum logic [1:0] {
        LD_IDLE    = 2'd0,
        LD_COLLECT = 2'd1,
        LD_WRITE   = 2'd2,
        LD_DONE    = 2'd3
    } ld_state_e;

    localparam int unsigned BYTE_W = 8;

    // Number of stream bytes that make up one memory word.
    function automatic int unsigned bytes_per_word(input int unsigned dw);
        return dw / BYTE_W;
    endfunction

    // Width of a counter that indexes bytes within a word (never zero).
    function automatic int unsigned byte_cnt_width(input int unsigned bpw);
        return (bpw > 1) ? $clog2(bpw) : 1;
    endfunction

endpackage

// File: rtl/imem_byte_packer.sv
// Packs accepted stream bytes into a DW-bit word; DW must be at least 16 and a multiple of 8.
// Latency: word_o/word_vld_o are combinational on the byte that completes the word.
// Backpressure: none here; the caller only asserts byte_vld_i for bytes it has accepted.
module imem_byte_packer #(
    parameter int unsigned DW      = 32,
    parameter bit          BIG_END = 1'b1
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          byte_vld_i,
    input  logic [7:0]    byte_dat_i,
    output logic [DW-1:0] word_o,
    output logic          word_vld_o
);
    import imem_loader_pkg::*;

    localparam int unsigned BPW = bytes_per_word(DW);
    localparam int unsigned CW  = byte_cnt_width(BPW);

    // Holds the bytes of the current word received so far; the newest byte is merged in
    // combinationally so the full word is available on the cycle its last byte arrives.
    logic [DW-9:0] hist_q;
    logic [DW-9:0] hist_d;
    logic [CW-1:0] cnt_q;

    if (BIG_END) begin : g_big
        assign word_o = {hist_q, byte_dat_i};
        assign hist_d = word_o[DW-9:0];
    end else begin : g_little
        assign word_o = {byte_dat_i, hist_q};
        assign hist_d = word_o[DW-1:8];
    end

    assign word_vld_o = byte_vld_i && (cnt_q == CW'(BPW - 1));

    // Shift in each accepted byte and count bytes, wrapping after a full word.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            hist_q <= '0;
            cnt_q  <= '0;
        end else if (byte_vld_i) begin
            hist_q <= hist_d;
            cnt_q  <= word_vld_o ? '0 : cnt_q + CW'(1);
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Loads a byte stream into instruction memory as packed words and holds the core in reset until done.
// Latency: mem_wen_o pulses the cycle after the last byte of a word; one word per DW/8+1 cycles at best.
// Backpressure: s_ready_o is high only while collecting bytes; the memory port never stalls.
module imem_loader #(
    parameter int unsigned   DW        = 32,
    parameter int unsigned   AW        = 32,
    parameter logic [AW-1:0] BASE_ADDR = '0,
    parameter int unsigned   ADDR_STEP = 1,
    parameter int unsigned   MAX_WORDS = 256,
    parameter bit            BIG_END   = 1'b1
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          start_i,
    input  logic [15:0]   len_i,
    input  logic          s_valid_i,
    input  logic [7:0]    s_data_i,
    output logic          s_ready_o,
    output logic          mem_wen_o,
    output logic [AW-1:0] mem_addr_o,
    output logic [DW-1:0] mem_wdata_o,
    output logic          busy_o,
    output logic          done_o,
    output logic          len_err_o,
    output logic          core_rstn_o
);
    import imem_loader_pkg::*;

    ld_state_e     state_q;
    logic [15:0]   len_q;
    logic [15:0]   idx_q;
    logic [15:0]   idx_d;
    logic [AW-1:0] addr_d;
    logic          mem_wen_q;
    logic [AW-1:0] mem_addr_q;
    logic [DW-1:0] mem_wdata_q;
    logic          busy_q;
    logic          done_q;
    logic          len_err_q;
    logic          core_rstn_q;

    logic          byte_acc;
    logic [DW-1:0] word;
    logic          word_vld;
    logic          len_over;
    logic [15:0]   len_clamp;

    assign s_ready_o = (state_q == LD_COLLECT);
    assign byte_acc  = s_valid_i && s_ready_o;

    imem_byte_packer #(
        .DW      (DW),
        .BIG_END (BIG_END)
    ) u_packer (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .byte_vld_i (byte_acc),
        .byte_dat_i (s_data_i),
        .word_o     (word),
        .word_vld_o (word_vld)
    );

    // Oversized requests are clamped rather than rejected so the core still gets a load.
    assign len_over  = ({16'd0, len_i} > 32'(MAX_WORDS));
    assign len_clamp = len_over ? 16'(MAX_WORDS) : len_i;
    assign idx_d     = idx_q + 16'd1;
    // Address arithmetic wraps naturally at AW bits.
    assign addr_d    = BASE_ADDR + AW'(idx_q) * AW'(ADDR_STEP);

    // Load sequencing: accept start, collect bytes, write words, then release the core.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= LD_IDLE;
            len_q       <= '0;
            idx_q       <= '0;
            mem_wen_q   <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            len_err_q   <= 1'b0;
            core_rstn_q <= 1'b0;
        end else begin
            mem_wen_q <= 1'b0;
            unique case (state_q)
                LD_IDLE, LD_DONE: begin
                    if (state_q == LD_DONE) begin
                        done_q      <= 1'b1;
                        core_rstn_q <= 1'b1;
                    end
                    if (start_i) begin
                        done_q      <= 1'b0;
                        core_rstn_q <= 1'b0;
                        len_err_q   <= len_over;
                        len_q       <= len_clamp;
                        idx_q       <= '0;
                        if (len_i == 16'd0) begin
                            state_q <= LD_DONE;
                        end else begin
                            state_q <= LD_COLLECT;
                            busy_q  <= 1'b1;
                        end
                    end
                end
                LD_COLLECT: begin
                    if (word_vld) begin
                        state_q     <= LD_WRITE;
                        mem_wen_q   <= 1'b1;
                        mem_addr_q  <= addr_d;
                        mem_wdata_q <= word;
                    end
                end
                LD_WRITE: begin
                    idx_q <= idx_d;
                    if (idx_d == len_q) begin
                        state_q <= LD_DONE;
                        busy_q  <= 1'b0;
                    end else begin
                        state_q <= LD_COLLECT;
                    end
                end
                default: state_q <= LD_IDLE;
            endcase
        end
    end

    assign mem_wen_o   = mem_wen_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign len_err_o   = len_err_q;
    assign core_rstn_o = core_rstn_q;

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: instance 0 uses defaults (big-endian, base 0),
// instance 1 is little-endian with base address 32'hFFFFFFFF to exercise wrap.
// Expected writes are queued by the stimulus and popped by per-instance monitors.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        start     [2];
    logic [15:0] len       [2];
    logic        s_valid   [2];
    logic [7:0]  s_data    [2];
    logic        s_ready   [2];
    logic        mem_wen   [2];
    logic [31:0] mem_addr  [2];
    logic [31:0] mem_wdata [2];
    logic        busy      [2];
    logic        done      [2];
    logic        len_err   [2];
    logic        core_rstn [2];

    int n_chk = 0;
    int n_err = 0;
    int wr_cnt [2];
    logic [63:0] q0 [$];
    logic [63:0] q1 [$];

    always #5 clk = ~clk;

    imem_loader u_dut0 (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .start_i     (start[0]),
        .len_i       (len[0]),
        .s_valid_i   (s_valid[0]),
        .s_data_i    (s_data[0]),
        .s_ready_o   (s_ready[0]),
        .mem_wen_o   (mem_wen[0]),
        .mem_addr_o  (mem_addr[0]),
        .mem_wdata_o (mem_wdata[0]),
        .busy_o      (busy[0]),
        .done_o      (done[0]),
        .len_err_o   (len_err[0]),
        .core_rstn_o (core_rstn[0])
    );

    imem_loader #(
        .BASE_ADDR (32'hFFFF_FFFF),
        .ADDR_STEP (1),
        .BIG_END   (1'b0)
    ) u_dut1 (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .start_i     (start[1]),
        .len_i       (len[1]),
        .s_valid_i   (s_valid[1]),
        .s_data_i    (s_data[1]),
        .s_ready_o   (s_ready[1]),
        .mem_wen_o   (mem_wen[1]),
        .mem_addr_o  (mem_addr[1]),
        .mem_wdata_o (mem_wdata[1]),
        .busy_o      (busy[1]),
        .done_o      (done[1]),
        .len_err_o   (len_err[1]),
        .core_rstn_o (core_rstn[1])
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard pop for one observed write.
    task automatic mon(input int u);
        logic [63:0] e;
        wr_cnt[u]++;
        chk("ready_low_during_write", 64'(s_ready[u]), 64'd0);
        if ((u == 0 ? q0.size() : q1.size()) == 0) begin
            chk("unexpected_write", {mem_addr[u], mem_wdata[u]}, 64'hDEAD_0000_DEAD_0000);
        end else begin
            e = (u == 0) ? q0.pop_front() : q1.pop_front();
            chk("write_addr_data", {mem_addr[u], mem_wdata[u]}, e);
        end
    endtask

    always @(negedge clk) if (rst_n && mem_wen[0] === 1'b1) mon(0);
    always @(negedge clk) if (rst_n && mem_wen[1] === 1'b1) mon(1);

    task automatic chk_reset_vals(input int u);
        chk("rst_s_ready",   64'(s_ready[u]),   64'd0);
        chk("rst_mem_wen",   64'(mem_wen[u]),   64'd0);
        chk("rst_mem_addr",  64'(mem_addr[u]),  64'd0);
        chk("rst_mem_wdata", 64'(mem_wdata[u]), 64'd0);
        chk("rst_busy",      64'(busy[u]),      64'd0);
        chk("rst_done",      64'(done[u]),      64'd0);
        chk("rst_len_err",   64'(len_err[u]),   64'd0);
        chk("rst_core_rstn", 64'(core_rstn[u]), 64'd0);
    endtask

    task automatic start_ld(input int u, input logic [15:0] n, input bit accepted);
        start[u] = 1'b1;
        len[u]   = n;
        @(negedge clk);
        start[u] = 1'b0;
        len[u]   = 16'($urandom());
        if (accepted) begin
            chk("start_clears_done", 64'(done[u]),      64'd0);
            chk("start_core_rstn",   64'(core_rstn[u]), 64'd0);
        end
    endtask

    // Idle gap cycles first, then offer the byte until it is accepted.
    task automatic send_byte(input int u, input logic [7:0] b, input int gap);
        int t = 0;
        repeat (gap) @(negedge clk);
        s_valid[u] = 1'b1;
        s_data[u]  = b;
        while (s_ready[u] !== 1'b1 && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (t >= 100) chk("byte_accept_timeout", 64'(t), 64'd0);
        @(negedge clk);
        s_valid[u] = 1'b0;
        s_data[u]  = 8'($urandom());
    endtask

    task automatic send_word(input int u, input logic [31:0] a, input logic [31:0] w,
                             input int gap, input bit mid_start);
        logic [7:0] b;
        if (u == 0) q0.push_back({a, w});
        else        q1.push_back({a, w});
        for (int i = 0; i < 4; i++) begin
            b = (u == 0) ? w[31-8*i -: 8] : w[8*i +: 8];
            send_byte(u, b, gap);
            if (mid_start && i == 1) begin
                start_ld(u, 16'd5, 1'b0);
                chk("busy_after_ignored_start", 64'(busy[u]), 64'd1);
            end
        end
        chk("wen_latency", 64'(mem_wen[u]), 64'd1);
    endtask

    task automatic wait_done(input int u);
        int t = 0;
        while (done[u] !== 1'b1 && t < 2000) begin
            @(negedge clk);
            t++;
        end
        chk("done", 64'(done[u]), 64'd1);
        chk("core_rstn_released", 64'(core_rstn[u]), 64'd1);
        chk("busy_clear", 64'(busy[u]), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int c0;
        for (int u = 0; u < 2; u++) begin
            start[u] = 1'b0; len[u] = '0; s_valid[u] = 1'b0; s_data[u] = '0; wr_cnt[u] = 0;
        end
        // Reset state
        repeat (3) @(negedge clk);
        chk_reset_vals(0);
        chk_reset_vals(1);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_core_held", 64'(core_rstn[0]), 64'd0);

        // Reset in the middle of collecting a word discards it
        start_ld(0, 16'd1, 1'b1);
        send_byte(0, 8'hAA, 0);
        send_byte(0, 8'hBB, 0);
        chk("busy_mid_collect", 64'(busy[0]), 64'd1);
        #2 rst_n = 1'b0;
        #1 chk_reset_vals(0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        start_ld(0, 16'd1, 1'b1);
        send_word(0, 32'd0, 32'h1122_3344, 0, 1'b0);
        wait_done(0);

        // Basic two-word load with valid held high
        start_ld(0, 16'd2, 1'b1);
        send_word(0, 32'd0, 32'h2001_0005, 0, 1'b0);
        send_word(0, 32'd1, 32'h0022_1820, 0, 1'b0);
        wait_done(0);
        repeat (3) @(negedge clk);
        chk("hold_addr",  64'(mem_addr[0]),  64'd1);
        chk("hold_wdata", 64'(mem_wdata[0]), 64'h0022_1820);

        // Same load with valid toggling
        c0 = wr_cnt[0];
        start_ld(0, 16'd2, 1'b1);
        send_word(0, 32'd0, 32'h2001_0005, 1, 1'b0);
        send_word(0, 32'd1, 32'h0022_1820, 1, 1'b0);
        wait_done(0);
        chk("gap_write_count", 64'(wr_cnt[0] - c0), 64'd2);

        // Zero-length load writes nothing
        c0 = wr_cnt[0];
        start_ld(0, 16'd0, 1'b1);
        wait_done(0);
        repeat (5) @(negedge clk);
        chk("len0_no_writes", 64'(wr_cnt[0] - c0), 64'd0);
        chk("len0_len_err", 64'(len_err[0]), 64'd0);

        // Oversized load is clamped to 256 words
        c0 = wr_cnt[0];
        start_ld(0, 16'd300, 1'b1);
        chk("len_err_set", 64'(len_err[0]), 64'd1);
        for (int i = 0; i < 256; i++)
            send_word(0, 32'(i), {8'(i), 8'(~i), 8'h5A, 8'(i ^ 8'h3C)}, 0, 1'b0);
        wait_done(0);
        repeat (8) @(negedge clk);
        chk("clamp_write_count", 64'(wr_cnt[0] - c0), 64'd256);
        chk("clamp_last_addr", 64'(mem_addr[0]), 64'd255);
        chk("len_err_held", 64'(len_err[0]), 64'd1);

        // Start pulse during collection is ignored
        c0 = wr_cnt[0];
        start_ld(0, 16'd2, 1'b1);
        chk("len_err_cleared", 64'(len_err[0]), 64'd0);
        send_word(0, 32'd0, 32'hCAFE_F00D, 0, 1'b1);
        send_word(0, 32'd1, 32'h0BAD_BEEF, 0, 1'b0);
        wait_done(0);
        repeat (8) @(negedge clk);
        chk("ignored_start_writes", 64'(wr_cnt[0] - c0), 64'd2);
        chk("ignored_start_done", 64'(done[0]), 64'd1);

        // Little-endian instance: address wrap, then restart from DONE
        start_ld(1, 16'd2, 1'b1);
        send_word(1, 32'hFFFF_FFFF, 32'hA1B2_C3D4, 0, 1'b0);
        send_word(1, 32'h0000_0000, 32'h0F1E_2D3C, 0, 1'b0);
        wait_done(1);
        start_ld(1, 16'd1, 1'b1);
        send_word(1, 32'hFFFF_FFFF, 32'h1122_3344, 0, 1'b0);
        wait_done(1);
        chk("le_write_count", 64'(wr_cnt[1]), 64'd3);

        repeat (4) @(negedge clk);
        chk("pending_writes_0", 64'(q0.size()), 64'd0);
        chk("pending_writes_1", 64'(q1.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
